// File: rtl/phy_probe_gen.sv
// phy_probe_gen: pattern stimulus generator for a PHY under test, with a
// latency-matched checker that compares the returned words against the
// stimulus it sent LATENCY cycles earlier.
module phy_probe_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned LATENCY  = 4,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  parameter logic [31:0] POLY     = 32'h8020_0003,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk_f,
  input  logic             reset_L,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      word_count,
  input  logic [7:0]       valid_pattern,
  input  logic [WIDTH-1:0] phy_output,
  input  logic             phy_output_valid,
  output logic [WIDTH-1:0] phy_input,
  output logic             valid,
  output logic [SEL_W-1:0] selector,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [15:0]      match_count,
  output logic             error
);

  localparam logic [WIDTH-1:0] SeedW = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] PolyW = WIDTH'(POLY);
  localparam logic [WIDTH-1:0] OneW  = WIDTH'(1);
  localparam logic [SEL_W-1:0] SelMax = SEL_W'(CHANNELS - 1);
  localparam logic [15:0]      DrainLast = 16'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [15:0]      wc_q;
  logic [7:0]       vp_q;
  logic [15:0]      idx_q;       // word index in RUN, drain cycle count in DRAIN
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] gen_q;       // data word for the current index
  logic [WIDTH-1:0] pipe_data_q [LATENCY];
  logic             pipe_vld_q  [LATENCY];
  logic [15:0]      err_q, match_q;
  logic             error_q;

  logic             chk_match, chk_err;
  logic [WIDTH-1:0] exp_data;
  logic             exp_vld;

  // First word of a run for the selected pattern.
  function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m);
    logic [WIDTH-1:0] w;
    unique case (m)
      2'd0, 2'd1: w = SeedW;
      2'd2:       w = '1;
      default:    w = OneW;
    endcase
    return w;
  endfunction

  // Word i+1 derived from word i; walking-one is a rotate so it wraps at WIDTH.
  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] w;
    unique case (m)
      2'd0:    w = cur + OneW;
      2'd1:    w = (cur >> 1) ^ (cur[0] ? PolyW : '0);
      2'd2:    w = ~cur;
      default: w = {cur[WIDTH-2:0], cur[WIDTH-1]};
    endcase
    return w;
  endfunction

  // State register.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (word_count == 16'd0) ? StDone : StRun;
      StRun:   if (idx_q == wc_q - 16'd1) state_d = StDrain;
      StDrain: if (idx_q == DrainLast) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; stimulus is only driven while in RUN.
  always_comb begin
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StDone);
    valid     = 1'b0;
    phy_input = '0;
    selector  = '0;
    if (state_q == StRun) begin
      valid     = vp_q[idx_q[2:0]];
      phy_input = gen_q;
      selector  = sel_q;
    end
  end

  // Checker compare against the stimulus delayed by LATENCY cycles.
  always_comb begin
    exp_data  = pipe_data_q[LATENCY-1];
    exp_vld   = pipe_vld_q[LATENCY-1];
    chk_match = 1'b0;
    chk_err   = 1'b0;
    if (busy) begin
      if (exp_vld) begin
        chk_match = phy_output_valid && (phy_output == exp_data);
        chk_err   = !chk_match;
      end else begin
        chk_err   = phy_output_valid;
      end
    end
  end

  // Run datapath: latched config, generator, expected pipeline and counters.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      mode_q  <= '0;
      wc_q    <= '0;
      vp_q    <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      gen_q   <= SeedW;
      err_q   <= '0;
      match_q <= '0;
      error_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_data_q[k] <= '0;
        pipe_vld_q[k]  <= 1'b0;
      end
    end else begin
      if (state_q == StIdle && start) begin
        mode_q  <= mode;
        wc_q    <= word_count;
        vp_q    <= valid_pattern;
        idx_q   <= '0;
        sel_q   <= '0;
        gen_q   <= first_word(mode);
        err_q   <= '0;
        match_q <= '0;
        error_q <= 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
          pipe_data_q[k] <= '0;
          pipe_vld_q[k]  <= 1'b0;
        end
      end
      if (busy) begin
        pipe_data_q[0] <= phy_input;
        pipe_vld_q[0]  <= valid;
        for (int k = 1; k < LATENCY; k++) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
          pipe_vld_q[k]  <= pipe_vld_q[k-1];
        end
        if (chk_match && match_q != 16'hFFFF) match_q <= match_q + 16'd1;
        if (chk_err && err_q != 16'hFFFF)     err_q   <= err_q + 16'd1;
        if (chk_err)                           error_q <= 1'b1;
      end
      if (state_q == StRun) begin
        // Index restarts at 0 so DRAIN can reuse it as its cycle counter.
        idx_q <= (state_d == StDrain) ? 16'd0 : idx_q + 16'd1;
        sel_q <= (sel_q == SelMax) ? '0 : sel_q + SEL_W'(1);
        gen_q <= next_word(mode_q, gen_q);
      end else if (state_q == StDrain) begin
        idx_q <= idx_q + 16'd1;
      end
    end
  end

  assign err_count   = err_q;
  assign match_count = match_q;
  assign error       = error_q;

endmodule

// File: tb/tb_phy_probe_gen.sv
// Directed bench for phy_probe_gen with a 4-cycle loopback PHY model that
// can flip bit 0 of one word or inject one spurious valid.
module tb_phy_probe_gen;

  localparam int unsigned L = 4;

  logic        clk_f = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] word_count = 16'd0;
  logic [7:0]  valid_pattern = 8'h00;
  logic [31:0] phy_output;
  logic        phy_output_valid;
  logic [31:0] phy_input;
  logic        valid;
  logic [0:0]  selector;
  logic        busy, done, error;
  logic [15:0] err_count, match_count;

  int checks = 0;
  int errors = 0;

  phy_probe_gen #(
    .WIDTH(32), .CHANNELS(2), .LATENCY(L), .SEED(32'h0000_0001), .POLY(32'h8020_0003)
  ) dut (
    .clk_f(clk_f), .reset_L(reset_L), .start(start), .mode(mode),
    .word_count(word_count), .valid_pattern(valid_pattern),
    .phy_output(phy_output), .phy_output_valid(phy_output_valid),
    .phy_input(phy_input), .valid(valid), .selector(selector), .busy(busy),
    .done(done), .err_count(err_count), .match_count(match_count), .error(error)
  );

  always #5 clk_f = ~clk_f;

  // Loopback PHY model.
  logic [31:0] dl_d [L];
  logic        dl_v [L];
  logic        flip_en = 1'b0;
  logic        spur_arm = 1'b0;
  logic        spur_used = 1'b0;
  logic        spur_fire;

  always @(posedge clk_f) begin
    dl_d[0] <= phy_input;
    dl_v[0] <= valid;
    for (int k = 1; k < L; k++) begin
      dl_d[k] <= dl_d[k-1];
      dl_v[k] <= dl_v[k-1];
    end
    if (spur_fire) spur_used <= 1'b1;
  end

  initial begin
    for (int k = 0; k < L; k++) begin
      dl_d[k] = '0;
      dl_v[k] = 1'b0;
    end
  end

  assign spur_fire = spur_arm && !spur_used && !dl_v[L-1] && busy;
  assign phy_output_valid = dl_v[L-1] | spur_fire;
  assign phy_output = dl_d[L-1] ^
                      {31'd0, flip_en && dl_v[L-1] && (dl_d[L-1] == 32'h0000_0020)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_f);
  endtask

  // Leaves the bench at the negedge of the first RUN (or DONE) cycle.
  task automatic start_run(input logic [1:0] m, input logic [15:0] wc, input logic [7:0] vp);
    mode = m;
    word_count = wc;
    valid_pattern = vp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse; expiry counts as a failure.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    // Reset values
    tick();
    chk("rst_phy_input", phy_input, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_counts", {err_count, match_count}, 32'd0);
    reset_L = 1'b1;
    tick();

    // Mode 0 loopback, all valid; start/word_count wiggled mid-run
    start_run(2'd0, 16'd20, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      chk("m0_data", phy_input, 32'(i + 1));
      chk("m0_sel", {31'd0, selector}, 32'(i % 2));
      chk("m0_valid_busy", {30'd0, valid, busy}, 32'd3);
      start = (i == 3);
      word_count = (i == 3) ? 16'd3 : 16'd20;
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < L; k++) begin
      chk("drain_out", {phy_input[29:0], valid, done}, 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("m0_done", {30'd0, busy, done}, 32'd1);
    chk("m0_match", {16'd0, match_count}, 32'd20);
    chk("m0_err", {15'd0, error, err_count}, 32'd0);
    tick();
    chk("m0_done_pulse", {30'd0, busy, done}, 32'd0);
    chk("m0_hold", {16'd0, match_count}, 32'd20);

    // Valid pattern 00110011: valid 1,1,0,0 while data keeps advancing
    start_run(2'd0, 16'd20, 8'b0011_0011);
    for (int i = 0; i < 4; i++) begin
      chk("vp_valid", {31'd0, valid}, (i < 2) ? 32'd1 : 32'd0);
      chk("vp_data", phy_input, 32'(i + 1));
      tick();
    end
    wait_done("vp");
    chk("vp_match", {16'd0, match_count}, 32'd10);
    chk("vp_err", {16'd0, err_count}, 32'd0);
    tick();

    // LFSR words: 1, 80200003, C0300002
    start_run(2'd1, 16'd3, 8'hFF);
    chk("lfsr_w0", phy_input, 32'h0000_0001);
    tick();
    chk("lfsr_w1", phy_input, 32'h8020_0003);
    tick();
    chk("lfsr_w2", phy_input, 32'hC030_0002);
    wait_done("lfsr");
    chk("lfsr_match", {16'd0, match_count}, 32'd3);
    tick();

    // Alternating pattern
    start_run(2'd2, 16'd2, 8'hFF);
    chk("alt_w0", phy_input, 32'hFFFF_FFFF);
    tick();
    chk("alt_w1", phy_input, 32'h0000_0000);
    wait_done("alt");
    chk("alt_match", {16'd0, match_count}, 32'd2);
    tick();

    // Walking one with bit 0 of word 5 corrupted by the PHY
    flip_en = 1'b1;
    start_run(2'd3, 16'd20, 8'hFF);
    for (int i = 0; i < 6; i++) tick();
    chk("walk_w6", phy_input, 32'h0000_0040);
    wait_done("walk");
    chk("walk_err", {15'd0, error, err_count}, {15'd0, 1'b1, 16'd1});
    chk("walk_match", {16'd0, match_count}, 32'd19);
    flip_en = 1'b0;
    tick();

    // One spurious valid during a delayed valid=0 slot
    spur_arm = 1'b1;
    start_run(2'd0, 16'd20, 8'b0011_0011);
    wait_done("spur");
    chk("spur_err", {15'd0, error, err_count}, {15'd0, 1'b1, 16'd1});
    chk("spur_match", {16'd0, match_count}, 32'd10);
    spur_arm = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("spur_hold", {15'd0, error, err_count}, {15'd0, 1'b1, 16'd1});

    // Zero-length run
    start_run(2'd0, 16'd0, 8'hFF);
    chk("wc0_done", {30'd0, busy, done}, 32'd1);
    chk("wc0_counts", {err_count, match_count}, 32'd0);
    chk("wc0_error", {31'd0, error}, 32'd0);
    tick();
    chk("wc0_idle", {30'd0, busy, done}, 32'd0);

    // Reset at word 7 aborts the run
    start_run(2'd0, 16'd20, 8'hFF);
    for (int i = 0; i < 7; i++) tick();
    chk("rst_w7", phy_input, 32'd8);
    #2 reset_L = 1'b0;
    #1;
    chk("arst_data", phy_input, 32'd0);
    chk("arst_ctl", {28'd0, valid, selector, busy, done}, 32'd0);
    chk("arst_counts", {err_count, match_count}, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    tick();
    reset_L = 1'b1;
    begin
      logic seen_done = 1'b0;
      logic seen_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
        seen_done |= done;
        seen_busy |= busy;
        tick();
      end
      chk("abort_no_done", {30'd0, seen_busy, seen_done}, 32'd0);
    end
    start_run(2'd0, 16'd5, 8'hFF);
    chk("rerun_w0", phy_input, 32'd1);
    wait_done("rerun");
    chk("rerun_counts", {err_count, match_count}, {16'd0, 16'd5});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_probe_gen.md
PHY_PROBE_GEN -- requirements
Module: phy_probe_gen

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of selector channels; SEL_W = max(1, ceil(log2(CHANNELS))).
REQ-003 The block SHALL have parameter LATENCY, default 4, range 1..16, giving the DUT round-trip delay in cycles.
REQ-004 The block SHALL have parameter SEED, default 32'h00000001, giving the first data value (LSBs taken if WIDTH<32; zero is forbidden in LFSR mode).
REQ-005 The block SHALL have parameter POLY, default 32'h80200003, giving the Galois LFSR tap mask (LSBs taken).

Interface
REQ-006 The block SHALL have port clk_f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: starts a run when sampled high in IDLE.
REQ-009 The block SHALL have port mode, input, 2 bits: pattern select (0 increment, 1 LFSR, 2 alternating, 3 walking-one).
REQ-010 The block SHALL have port word_count, input, 16 bits: number of words in the run.
REQ-011 The block SHALL have port valid_pattern, input, 8 bits: valid mask applied cyclically.
REQ-012 The block SHALL have port phy_output, input, WIDTH bits: data returned by the DUT.
REQ-013 The block SHALL have port phy_output_valid, input, 1 bit: qualifies phy_output.
REQ-014 The block SHALL have port phy_input, output, WIDTH bits: stimulus data to the DUT.
REQ-015 The block SHALL have port valid, output, 1 bit: stimulus valid.
REQ-016 The block SHALL have port selector, output, SEL_W bits: stimulus channel select.
REQ-017 The block SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-019 The block SHALL have port err_count, output, 16 bits: mismatch count, saturating.
REQ-020 The block SHALL have port match_count, output, 16 bits: correct-word count, saturating.
REQ-021 The block SHALL have port error, output, 1 bit: sticky flag, set on the first mismatch of a run.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; DONE lasts 1 cycle and then returns to IDLE.
REQ-023 IDLE + start=1 SHALL: latch mode, word_count and valid_pattern; clear counters, error and the expected pipeline; go to RUN; if word_count==0, go to DONE instead.
REQ-024 In RUN, word index i (0..word_count-1) SHALL advance every cycle, and word i SHALL drive phy_input, valid and selector in the cycle after the word i-1 cycle.
REQ-025 valid SHALL equal valid_pattern[i mod 8]; data SHALL advance regardless of valid.
REQ-026 selector SHALL equal i mod CHANNELS.
REQ-027 Data SHALL be: mode 0 SEED+i mod 2^WIDTH; mode 1 SEED then one Galois LFSR step per word with POLY; mode 2 all-ones if i even, all-zeros if i odd; mode 3 1 << (i mod WIDTH).
REQ-028 After word word_count-1, RUN SHALL go to DRAIN; DRAIN SHALL last exactly LATENCY cycles with valid=0, phy_input=0 and selector=0.
REQ-029 The checker SHALL delay {data, valid} by a LATENCY-deep shift register that is active in RUN and DRAIN.
REQ-030 Delayed valid=1: phy_output_valid=1 and phy_output==expected SHALL increment match_count; any other combination SHALL increment err_count and set error.
REQ-031 Delayed valid=0 with phy_output_valid=1 (spurious word) SHALL increment err_count and set error.
REQ-032 Counters SHALL saturate at 16'hFFFF with no wrap.
REQ-033 phy_output_valid SHALL be ignored in IDLE and DONE.
REQ-034 start SHALL be ignored outside IDLE, and latched inputs SHALL not change during a run.
REQ-035 err_count, match_count and error SHALL hold after DONE until the next accepted start.
REQ-036 In IDLE, valid, phy_input and selector SHALL be 0.

Reset
REQ-037 reset_L=0 SHALL asynchronously force: state IDLE; phy_input, valid, selector, busy, done, err_count, match_count and error to 0; pipeline cleared; LFSR reloaded with SEED.
REQ-038 Reset asserted mid-RUN or mid-DRAIN SHALL abort the run with no done pulse; operation SHALL resume only on a new start after reset_L=1.

Verification
REQ-039 Loopback with LATENCY-cycle delay, mode 0, word_count=20, valid_pattern=8'hFF -> phy_input 1..20, selector 0,1,0,1...; match_count=20, err_count=0, done pulses LATENCY+1 cycles after the last word.
REQ-040 Same setup with valid_pattern=8'b00110011 -> valid sequence 1,1,0,0 repeating; match_count=10, err_count=0.
REQ-041 Loopback with the DUT flipping bit 0 of word 5, mode 3 -> err_count=1, error=1, match_count=19.
REQ-042 DUT asserting phy_output_valid during a delayed valid=0 slot -> err_count increments by 1.
REQ-043 word_count=0 + start -> done pulses on the next cycle, busy never rises, counters 0.
REQ-044 reset_L pulsed low at word 7 of a run -> all outputs 0 immediately, no done; a new start runs cleanly from SEED.
